// File: rtl/arisco_pkg.sv
// Shared constants for the arisco pipeline: ALU opcodes, RV32I encodings and the
// output-slot state encoding, plus the instruction classifier used by decode.
package arisco_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b100,
    ALU_AND = 3'b111
  } alu_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    we;
    logic    illegal;
  } dec_t;

  // Anything not explicitly matched stays illegal with a zero (ADD) opcode.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d.alu_op  = ALU_ADD;
    d.use_imm = 1'b0;
    d.illegal = 1'b1;
    case (instr[6:0])
      OPC_OP: begin
        if (instr[31:25] == F7_BASE && instr[14:12] == F3_ADD_SUB) begin
          d.illegal = 1'b0;
        end else if (instr[31:25] == F7_ALT && instr[14:12] == F3_ADD_SUB) begin
          d.alu_op  = ALU_SUB;
          d.illegal = 1'b0;
        end else if (instr[31:25] == F7_BASE && instr[14:12] == F3_AND) begin
          d.alu_op  = ALU_AND;
          d.illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        d.use_imm = 1'b1;
        if (instr[14:12] == F3_ADD_SUB) begin
          d.illegal = 1'b0;
        end else if (instr[14:12] == F3_AND) begin
          d.alu_op  = ALU_AND;
          d.illegal = 1'b0;
        end
      end
      default: ;
    endcase
    d.we = !d.illegal;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / decoded-op-out handshake plus the write-back port of the decode stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_opcode;
  logic [XLEN-1:0] out_left;
  logic [XLEN-1:0] out_right;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_left, out_right, out_rd, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_opcode, out_left, out_right, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: x0 hard-wired to zero, two combinational read ports
// with write-back bypass, one write port.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  // x0 has no storage at all, so it can neither be written nor read back non-zero.
  logic [XLEN-1:0] regs_q [1:NREGS-1];

  // NOTE: this storage is architecturally required to clear on reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wb_en_i && wb_rd_i == 5'(i)) begin
        regs_q[i] <= wb_data_i;
      end
    end
  end

  // A write landing this cycle is forwarded so the reader sees the new value.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] ra);
    logic [XLEN-1:0] data;
    data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ra == 5'(i)) begin
        data = (wb_en_i && wb_rd_i == ra) ? wb_data_i : regs_q[i];
      end
    end
    return data;
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_i);
    rs2_data_o = read_port(rs2_i);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: classifies ADD/SUB/AND/ADDI/ANDI, reads operands and holds the
// result in a single-entry output slot with valid/ready flow control.
module decode_stage
  import arisco_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  slot_state_e     state_q, state_d;
  logic            accept;
  dec_t            dec;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [XLEN-1:0] left_d, right_d;
  logic [4:0]      rd_d;

  logic [2:0]      opcode_q;
  logic [XLEN-1:0] left_q, right_q;
  logic [4:0]      rd_q;
  logic            we_q, illegal_q;

  regfile #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs1_i     (bus.in_instr[19:15]),
    .rs2_i     (bus.in_instr[24:20]),
    .rs1_data_o(rs1_val),
    .rs2_data_o(rs2_val),
    .wb_en_i   (bus.wb_en),
    .wb_rd_i   (bus.wb_rd),
    .wb_data_i (bus.wb_data)
  );

  assign bus.in_ready = !rst && (state_q == SLOT_EMPTY || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (!accept && bus.out_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    dec     = decode_instr(bus.in_instr);
    imm     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    left_d  = '0;
    right_d = '0;
    rd_d    = '0;
    if (!dec.illegal) begin
      left_d  = rs1_val;
      right_d = dec.use_imm ? imm : rs2_val;
      rd_d    = bus.in_instr[11:7];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SLOT_EMPTY;
      opcode_q  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opcode_q  <= dec.alu_op;
        left_q    <= left_d;
        right_q   <= right_d;
        rd_q      <= rd_d;
        we_q      <= dec.we;
        illegal_q <= dec.illegal;
      end
    end
  end

  // Outputs read zero for the whole reset window, including its first cycle.
  assign bus.out_valid   = !rst && state_q == SLOT_FULL;
  assign bus.out_opcode  = rst ? '0 : opcode_q;
  assign bus.out_left    = rst ? '0 : left_q;
  assign bus.out_right   = rst ? '0 : right_q;
  assign bus.out_rd      = rst ? '0 : rd_q;
  assign bus.out_we      = !rst && we_q;
  assign bus.out_illegal = !rst && illegal_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, setting the register and operand width.
REQ-002 SHALL have parameter NREGS, default 32, setting the architectural register count; x0 is always included.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  instruction present on in_instr.
REQ-006 SHALL have port in_ready  out  1  stage accepts an instruction this cycle.
REQ-007 SHALL have port in_instr  in  32  RV32I instruction word.
REQ-008 SHALL have port wb_en  in  1  register write-back enable.
REQ-009 SHALL have port wb_rd  in  5  write-back destination index.
REQ-010 SHALL have port wb_data  in  XLEN  write-back value.
REQ-011 SHALL have port out_valid  out  1  decoded operation held on outputs.
REQ-012 SHALL have port out_ready  in  1  downstream ALU stage consumes this cycle.
REQ-013 SHALL have port out_opcode  out  3  ALU opcode: ADD=000, SUB=100, AND=111.
REQ-014 SHALL have port out_left  out  XLEN  ALU left operand (rs1 value).
REQ-015 SHALL have port out_right  out  XLEN  ALU right operand (rs2 value or sign-extended imm).
REQ-016 SHALL have port out_rd  out  5  destination register index.
REQ-017 SHALL have port out_we  out  1  result is to be written to out_rd.
REQ-018 SHALL have port out_illegal  out  1  instruction not in the supported set.

Function
REQ-019 SHALL hold one output register slot with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 SHALL drive in_ready = !rst && (!out_valid || out_ready), combinationally.
REQ-021 SHALL accept on in_valid && in_ready; the decoded result appears on the outputs the next cycle with out_valid=1 (latency 1).
REQ-022 SHALL transition EMPTY->FULL on accept, FULL->EMPTY on out_ready with no accept, and stay FULL on simultaneous consume and accept, loading the new instruction.
REQ-023 SHALL hold all out_* signals bit-stable while out_valid && !out_ready, and SHALL NOT refresh held operands from later write-backs.
REQ-024 SHALL decode R-type (opcode 0110011): funct7=0000000/funct3=000 -> ADD; funct7=0100000/funct3=000 -> SUB; funct7=0000000/funct3=111 -> AND; out_right = rs2 value.
REQ-025 SHALL decode I-type (opcode 0010011): funct3=000 -> ADDI (opcode 000); funct3=111 -> ANDI (opcode 111); out_right = sign-extend(instr[31:20]) to XLEN.
REQ-026 SHALL, for supported instructions, drive out_rd = instr[11:7], out_we=1 and out_illegal=0.
REQ-027 SHALL, for any other encoding, drive out_illegal=1, out_we=0, out_opcode=000 and out_left=out_right=0, and SHALL still occupy the slot for one handshake.
REQ-028 SHALL implement NREGS x XLEN registers with two combinational read ports and one write port written at the edge when wb_en=1.
REQ-029 SHALL read x0 as 0 and ignore writes to x0.
REQ-030 SHALL bypass: when an accept coincides with wb_en=1, wb_rd=rsN and rsN!=0, operand N SHALL take wb_data.
REQ-031 SHALL act on wb_en independently of the handshake state.

Reset
REQ-032 SHALL, while rst=1, force out_valid=0, all other out_* to 0 and every register to 0, and SHALL ignore in_valid and wb_en.
REQ-033 SHALL discard any held instruction when rst asserts mid-operation; the first accept is possible in the cycle after rst deasserts.

Structure
REQ-034 SHALL take ALU opcode constants (ADD/SUB/AND), RV opcode/funct3/funct7 constants and the EMPTY/FULL state encoding from shared package arisco_pkg, which the ALU also uses.
REQ-035 SHALL place register storage, x0 handling and bypass in sub-module regfile; decode and handshake logic reside in decode_stage.

Verification
REQ-036 SHALL test: write x1=4 and x2=3 via wb, then accept 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, opcode=000, left=4, right=3, rd=3, we=1.
REQ-037 SHALL test: x1=7, x2=3, accept 0x402081B3 (sub) -> opcode=100, left=7, right=3; addi x5,x1,-1 (0xFFF08293) -> opcode=000, right=0xFFFFFFFF, rd=5.
REQ-038 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, then one handshake per cycle once out_ready=1 (back-to-back, no bubble).
REQ-039 SHALL test: accept add x3,x1,x2 in the same cycle as wb_en=1, wb_rd=1, wb_data=9 -> left=9; wb_rd=0, wb_data=5, then read x0 -> 0.
REQ-040 SHALL test: accept 0x00000000 -> out_illegal=1, out_we=0; rst asserted while FULL -> out_valid=0 next cycle and x1 reads 0.
